// File: rtl/video_ctrl_pkg.sv
// Shared video control types: bar sweep states and fvht bit positions.
// DWELL_HI/DWELL_LO are used only when BAR_SWEEP_DWELL_EN is defined.
package video_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    DOWN,
    DWELL_HI,
    DWELL_LO
  } bar_state_e;

  localparam int FVHT_V_BIT = 2;
  localparam int FVHT_H_BIT = 1;

endpackage

// File: rtl/rise_edge_detect.sv
// Registered last-value rising edge detector.
// RST_VAL=1 suppresses an event when the input is already high out of reset.
module rise_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_n_reset,
  input  logic i_sig,
  output logic o_rise
);

  logic last_q;

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) last_q <= RST_VAL;
    else            last_q <= i_sig;
  end

  assign o_rise = i_sig & ~last_q;

endmodule

// File: rtl/bar_sweep_controller.sv
// Per-frame ping-pong bar start scheduler, updated on vblank rise.
// Define BAR_SWEEP_DWELL_EN to hold DWELL_FRAMES frames at each endpoint.
module bar_sweep_controller
  import video_ctrl_pkg::*;
#(
  parameter int POS_W        = 13,
  parameter int WID_W        = 8,
  parameter int POS_MAX      = 3800,
  parameter int DWELL_FRAMES = 60
) (
  input  logic             i_clk,
  input  logic             i_n_reset,
  input  logic [3:0]       i_fvht,
  input  logic             i_enable,
  input  logic [3:0]       i_step,
  input  logic [WID_W-1:0] i_bar_width,
  output logic [POS_W-1:0] o_bar_start,
  output logic [WID_W-1:0] o_bar_width,
  output logic             o_bar_active,
  output logic             o_dir,
  output logic             o_frame_tick
);

  localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX);

`ifdef BAR_SWEEP_DWELL_EN
  localparam bar_state_e AT_TOP = DWELL_HI;
  localparam bar_state_e AT_BOT = DWELL_LO;
  localparam int CNT_W = $clog2(DWELL_FRAMES + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_FRAMES);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
`else
  localparam bar_state_e AT_TOP = DOWN;
  localparam bar_state_e AT_BOT = UP;
`endif

  logic evt;
  bar_state_e state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [WID_W-1:0] width_q, width_d;
  logic active_q, active_d;
  logic dir_q, dir_d;
  logic tick_q, tick_d;
  logic [POS_W:0] pos_x, step_x, sum;
  logic unused_fvht;

  rise_edge_detect #(
    .RST_VAL(1'b1)
  ) u_vb_edge (
    .i_clk    (i_clk),
    .i_n_reset(i_n_reset),
    .i_sig    (i_fvht[FVHT_V_BIT]),
    .o_rise   (evt)
  );

  assign unused_fvht = ^{i_fvht[3], i_fvht[FVHT_H_BIT],
                         i_fvht[0], (DWELL_FRAMES != 0)};

  // One extra bit so pos + step never wraps before the clamp test.
  assign pos_x  = {1'b0, pos_q};
  assign step_x = {{(POS_W - 3){1'b0}}, i_step};
  assign sum    = pos_x + step_x;

`ifdef BAR_SWEEP_DWELL_EN
  assign cnt_inc = cnt_q + 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    width_d  = width_q;
    active_d = active_q;
    dir_d    = dir_q;
    tick_d   = 1'b0;
`ifdef BAR_SWEEP_DWELL_EN
    cnt_d    = cnt_q;
`endif
    if (!i_enable) begin
      state_d  = IDLE;
      pos_d    = '0;
      dir_d    = 1'b0;
      active_d = 1'b0;
`ifdef BAR_SWEEP_DWELL_EN
      cnt_d    = '0;
`endif
    end else if (evt) begin
      tick_d  = 1'b1;
      width_d = i_bar_width;
      case (state_q)
        IDLE: begin
          state_d = UP;
          pos_d   = '0;
        end
        UP: begin
          if (i_step != 4'd0) begin
            if (sum >= {1'b0, POS_TOP}) begin
              pos_d   = POS_TOP;
              dir_d   = 1'b1;
              state_d = AT_TOP;
            end else begin
              pos_d = sum[POS_W-1:0];
            end
          end
        end
        DOWN: begin
          if (i_step != 4'd0) begin
            if (pos_x <= step_x) begin
              pos_d   = '0;
              dir_d   = 1'b0;
              state_d = AT_BOT;
            end else begin
              pos_d = pos_q - step_x[POS_W-1:0];
            end
          end
        end
`ifdef BAR_SWEEP_DWELL_EN
        DWELL_HI: begin
          if (cnt_inc >= DWELL_LAST) begin
            state_d = DOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DWELL_LO: begin
          if (cnt_inc >= DWELL_LAST) begin
            state_d = UP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          pos_d   = '0;
          dir_d   = 1'b0;
        end
      endcase
      active_d = (state_d != IDLE) && (i_bar_width != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      width_q  <= '0;
      active_q <= 1'b0;
      dir_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      width_q  <= width_d;
      active_q <= active_d;
      dir_q    <= dir_d;
      tick_q   <= tick_d;
    end
  end

`ifdef BAR_SWEEP_DWELL_EN
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`endif

  assign o_bar_start  = pos_q;
  assign o_bar_width  = width_q;
  assign o_bar_active = active_q;
  assign o_dir        = dir_q;
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_bar_sweep_controller.sv
// Randomized self-checking bench for bar_sweep_controller.
// Reference model follows the sweep rules with plain integer arithmetic.
module tb_bar_sweep_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  fvht;
  logic        en;
  logic [3:0]  step;
  logic [7:0]  bw;
  logic [12:0] bar_start;
  logic [7:0]  bar_width;
  logic        active;
  logic        dir;
  logic        tick;

  int n_checks = 0;
  int n_fails  = 0;
  int tick_cnt = 0;
  int frame_ticks;

  int m_pos, m_dir, m_width;
  bit m_run, m_active;

  always #5 clk = ~clk;

  always @(negedge clk) if (tick === 1'b1) tick_cnt++;

  bar_sweep_controller dut (
    .i_clk       (clk),
    .i_n_reset   (rst_n),
    .i_fvht      (fvht),
    .i_enable    (en),
    .i_step      (step),
    .i_bar_width (bw),
    .o_bar_start (bar_start),
    .o_bar_width (bar_width),
    .o_bar_active(active),
    .o_dir       (dir),
    .o_frame_tick(tick)
  );

  function automatic void model_clear();
    m_run = 0; m_pos = 0; m_dir = 0; m_active = 0;
  endfunction

  function automatic void model_evt(int st, int w);
    if (!m_run) begin
      m_run = 1;
      m_pos = 0;
    end else if (st != 0) begin
      if (m_dir == 0) begin
        if (m_pos + st >= 3800) begin
          m_pos = 3800; m_dir = 1;
        end else m_pos = m_pos + st;
      end else begin
        if (m_pos <= st) begin
          m_pos = 0; m_dir = 0;
        end else m_pos = m_pos - st;
      end
    end
    m_width  = w;
    m_active = (w != 0);
  endfunction

  // One vblank pulse; step/width are scrambled right after the event edge.
  task automatic frame(input int st, input int w, input int hold);
    int t0;
    t0 = tick_cnt;
    @(negedge clk);
    step = 4'(st); bw = 8'(w); fvht[2] = 1'b1;
    @(negedge clk);
    step = 4'($urandom); bw = 8'($urandom);
    repeat (hold) @(negedge clk);
    fvht[2] = 1'b0;
    @(negedge clk);
    frame_ticks = tick_cnt - t0;
    if (en) model_evt(st, w);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; fvht = 4'h0; step = 4'd0; bw = 8'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bar_start !== 13'd0) begin
      n_fails++; $display("FAIL reset_pos got %0d want 0", bar_start);
    end
    n_checks++;
    if ({bar_width, active, dir, tick} !== 11'd0) begin
      n_fails++;
      $display("FAIL reset_outs got w=%0d a=%b d=%b t=%b want 0",
               bar_width, active, dir, tick);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    m_width = 0; model_clear();
  endtask

  task automatic test_basic_sweep();
    int exp_pos[3] = '{0, 10, 20};
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      frame(10, 40, 2);
      n_checks++;
      if (bar_start !== 13'(exp_pos[k])) begin
        n_fails++;
        $display("FAIL basic_pos[%0d] got %0d want %0d", k, bar_start, exp_pos[k]);
      end
      n_checks++;
      if (active !== 1'b1 || bar_width !== 8'd40) begin
        n_fails++;
        $display("FAIL basic_act[%0d] got a=%b w=%0d want a=1 w=40", k, active, bar_width);
      end
      n_checks++;
      if (frame_ticks != 1) begin
        n_fails++; $display("FAIL basic_tick[%0d] got %0d want 1", k, frame_ticks);
      end
    end
  endtask

  task automatic test_top_clamp();
    while (3797 - m_pos >= 15) frame(15, 40, 1);
    if (3797 - m_pos > 0) frame(3797 - m_pos, 40, 1);
    n_checks++;
    if (bar_start !== 13'd3797 || dir !== 1'b0) begin
      n_fails++; $display("FAIL top_pre got %0d/%b want 3797/0", bar_start, dir);
    end
    frame(7, 40, 1);
    n_checks++;
    if (bar_start !== 13'd3800 || dir !== 1'b1) begin
      n_fails++; $display("FAIL top_clamp got %0d/%b want 3800/1", bar_start, dir);
    end
    frame(7, 40, 1);
    n_checks++;
    if (bar_start !== 13'd3793) begin
      n_fails++; $display("FAIL top_after got %0d want 3793", bar_start);
    end
  endtask

  task automatic test_bottom();
    while (m_pos - 15 >= 5) frame(15, 40, 1);
    if (m_pos > 5) frame(m_pos - 5, 40, 1);
    n_checks++;
    if (bar_start !== 13'd5 || dir !== 1'b1) begin
      n_fails++; $display("FAIL bot_pre got %0d/%b want 5/1", bar_start, dir);
    end
    frame(10, 40, 1);
    n_checks++;
    if (bar_start !== 13'd0 || dir !== 1'b0) begin
      n_fails++; $display("FAIL bot_clamp got %0d/%b want 0/0", bar_start, dir);
    end
    frame(10, 40, 1);
    n_checks++;
    if (bar_start !== 13'd10) begin
      n_fails++; $display("FAIL bot_after got %0d want 10", bar_start);
    end
  endtask

  task automatic test_vb_hold();
    frame(9, 40, 500);
    n_checks++;
    if (frame_ticks != 1) begin
      n_fails++; $display("FAIL hold_ticks got %0d want 1", frame_ticks);
    end
    n_checks++;
    if (bar_start !== 13'(m_pos) || m_pos != 19) begin
      n_fails++; $display("FAIL hold_pos got %0d want 19", bar_start);
    end
    frame(0, 40, 1);
    n_checks++;
    if (bar_start !== 13'd19 || frame_ticks != 1) begin
      n_fails++;
      $display("FAIL step0 got pos %0d ticks %0d want 19/1", bar_start, frame_ticks);
    end
  endtask

  task automatic test_reset_vb_high();
    int t0;
    @(negedge clk);
    fvht[2] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bar_start !== 13'd0 || active !== 1'b0) begin
      n_fails++; $display("FAIL async_rst got %0d/%b want 0/0", bar_start, active);
    end
    model_clear(); m_width = 0;
    t0 = tick_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (tick_cnt != t0 || active !== 1'b0 || bar_start !== 13'd0) begin
      n_fails++;
      $display("FAIL rst_vb_high got ticks %0d a=%b pos=%0d want 0/0/0",
               tick_cnt - t0, active, bar_start);
    end
    fvht[2] = 1'b0;
    frame(11, 33, 1);
    n_checks++;
    if (bar_start !== 13'd0 || active !== 1'b1 || bar_width !== 8'd33) begin
      n_fails++;
      $display("FAIL rst_restart got %0d/%b/%0d want 0/1/33", bar_start, active, bar_width);
    end
  endtask

  task automatic test_disable();
    while (m_pos < 1200) frame(15, 40, 1);
    n_checks++;
    if (bar_start !== 13'd1200) begin
      n_fails++; $display("FAIL dis_pre got %0d want 1200", bar_start);
    end
    en = 1'b0;
    @(negedge clk);
    model_clear();
    n_checks++;
    if (bar_start !== 13'd0 || active !== 1'b0 || dir !== 1'b0) begin
      n_fails++; $display("FAIL dis_clear got %0d/%b/%b want 0/0/0", bar_start, active, dir);
    end
    frame(5, 40, 1);
    n_checks++;
    if (frame_ticks != 0 || bar_start !== 13'd0) begin
      n_fails++; $display("FAIL dis_evt got ticks %0d pos %0d want 0/0", frame_ticks, bar_start);
    end
    en = 1'b1;
    frame(5, 40, 1);
    n_checks++;
    if (active !== 1'b1 || bar_start !== 13'd0) begin
      n_fails++; $display("FAIL reen got %b/%0d want 1/0", active, bar_start);
    end
  endtask

  task automatic test_width_zero();
    frame(12, 0, 1);
    n_checks++;
    if (active !== 1'b0 || bar_start !== 13'd12 || bar_width !== 8'd0) begin
      n_fails++;
      $display("FAIL wid0 got a=%b pos=%0d w=%0d want 0/12/0", active, bar_start, bar_width);
    end
    frame(12, 5, 1);
    n_checks++;
    if (active !== 1'b1 || bar_start !== 13'd24) begin
      n_fails++; $display("FAIL wid5 got a=%b pos=%0d want 1/24", active, bar_start);
    end
  endtask

  task automatic test_random();
    int st, w;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        en = 1'b0;
        @(negedge clk);
        model_clear();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        en = 1'b1;
      end
      st = $urandom_range(0, 15);
      w  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      fvht[1] = 1'($urandom);
      frame(st, w, $urandom_range(0, 3));
      n_checks++;
      if (bar_start !== 13'(m_pos) || dir !== 1'(m_dir)) begin
        n_fails++;
        $display("FAIL rnd_pos[%0d] got %0d/%b want %0d/%0d", k, bar_start, dir, m_pos, m_dir);
      end
      n_checks++;
      if (bar_width !== 8'(m_width) || active !== m_active || frame_ticks != 1) begin
        n_fails++;
        $display("FAIL rnd_out[%0d] got w=%0d a=%b t=%0d want %0d/%b/1",
                 k, bar_width, active, frame_ticks, m_width, m_active);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_top_clamp();
    test_bottom();
    test_vb_hold();
    test_reset_vb_high();
    test_disable();
    test_width_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bar_sweep_controller.md
# bar_sweep_controller

Per-frame scheduler for the line-inversion bar datapath. It tracks the video timing flags, and on every vertical-blank rising edge it advances a ping-pong bar start position between 0 and a programmable maximum. It also latches the bar width for the coming frame. The downstream per-line delay and width counters consume `o_bar_start` and `o_bar_width` and never see a value change mid-frame.

## Interface

Parameters:
- `POS_W`, default 13: width of the bar start position.
- `WID_W`, default 8: width of the bar width field.
- `POS_MAX`, default 3800: upper sweep endpoint, in pixel clocks after horizontal blank falls.
- `DWELL_FRAMES`, default 60: frames held at each endpoint. Used only when `BAR_SWEEP_DWELL_EN` is defined.

Ports:
- `i_clk`, in, 1: pixel clock. Every register is rising-edge clocked.
- `i_n_reset`, in, 1: asynchronous active-low reset.
- `i_fvht`, in, 4: video timing flags. Bit 2 is vertical blank; bit 1 is horizontal blank.
- `i_enable`, in, 1: sweep enable.
- `i_step`, in, 4: position increment per frame.
- `i_bar_width`, in, `WID_W`: requested bar width.
- `o_bar_start`, out, `POS_W`: current frame's bar start position.
- `o_bar_width`, out, `WID_W`: current frame's bar width.
- `o_bar_active`, out, 1: the bar is to be drawn this frame.
- `o_dir`, out, 1: sweep direction, 0 = up, 1 = down.
- `o_frame_tick`, out, 1: one-cycle pulse on each update event.

## Operation

- Edge detect:
  - `vb_last` registers `i_fvht[2]`.
  - Event: `evt = i_fvht[2] & ~vb_last`.
- States: IDLE, UP, DOWN. DWELL_HI and DWELL_LO exist only with the macro.
- Every transition below happens on a clock edge where `evt` is 1, except where stated otherwise.
- `i_enable` = 0 forces the following on the next clock, overriding everything else:
  - state IDLE, pos 0, `o_dir` 0;
  - `o_bar_active` 0 and `o_frame_tick` 0.
- IDLE with `i_enable` = 1, on evt:
  - go to UP; pos stays 0;
  - latch `o_bar_width`.
- UP, on evt:
  - if pos + `i_step` >= `POS_MAX`: pos = `POS_MAX`, go to DOWN (or DWELL_HI), `o_dir` = 1;
  - else pos += `i_step`.
- DOWN, on evt:
  - if pos <= `i_step`: pos = 0, go to UP (or DWELL_LO), `o_dir` = 0;
  - else pos -= `i_step`.
- Sum width: the addition uses `POS_W` + 1 bits, so there is no wrap-around.
- Step 0: pos is frozen and the state does not change, including at endpoints.
- On every evt in a non-IDLE state, and on IDLE->UP, `o_bar_width` is loaded from `i_bar_width`.
- `o_bar_active` = (state != IDLE) and (`o_bar_width` != 0). It is registered and updated on evt, or cleared by disable.
- `o_frame_tick` is 1 for exactly one cycle on every evt edge while enabled.
- `o_bar_start` is the pos register itself. No combinational path runs from the inputs to the outputs.

## Timing

- Reset values:
  - pos, `o_bar_start`, `o_bar_width`: 0;
  - `o_bar_active`, `o_dir`, `o_frame_tick`: 0;
  - state IDLE, dwell counter 0.
- `vb_last` resets to 1. If vertical blank is already high at reset release, no spurious event is generated.
- Latency:
  - New outputs appear on the same clock edge that samples `i_fvht[2]` = 1 with `vb_last` = 0.
  - They are visible in the following cycle.
- Only one update happens per frame. Vertical blank held high for many cycles produces one event.
- `i_step` and `i_bar_width` are sampled only at evt. They may change at any other time without effect.
- Reset asserted mid-frame clears everything immediately. The sweep restarts from IDLE.

## Configuration

`BAR_SWEEP_DWELL_EN`:
- Defined:
  - Reaching `POS_MAX` enters DWELL_HI; reaching 0 enters DWELL_LO.
  - Each dwell state counts evt edges. After `DWELL_FRAMES` events it goes to DOWN (from DWELL_HI) or UP (from DWELL_LO).
  - pos is held during the dwell; `o_bar_active` stays 1.
  - The counter is `$clog2(DWELL_FRAMES+1)` bits and clears on state exit.
- Undefined:
  - The direction reverses on the endpoint event itself.
  - The dwell states and counter are absent.

## Structure

- Shared package `video_ctrl_pkg` holds:
  - `bar_state_e` (the enum IDLE/UP/DOWN/DWELL_HI/DWELL_LO);
  - `FVHT_V_BIT` = 2 and `FVHT_H_BIT` = 1.
- One sub-module, `rise_edge_detect`, holds the registered last-value and the pulse output. Its reset value is a parameter, set to 1 here.
- The state machine and position arithmetic stay in the top module.

## Test plan

- Reset, then enable with step 10 and width 40, and 3 vertical-blank pulses:
  - `o_bar_start` reads 0, 10, 20;
  - `o_bar_active` = 1 and `o_bar_width` = 40 from the first event.
- Step 7 with pos 3797 in UP, one event:
  - pos clamps to 3800 and `o_dir` = 1;
  - the next event gives 3793.
- DOWN at pos 5 with step 10:
  - the event gives pos 0 and `o_dir` = 0;
  - the next event gives 10.
  - With the macro and `DWELL_FRAMES` = 3: pos stays 0 for 3 events, then gives 10.
- Vertical blank held high for 500 cycles:
  - exactly one `o_frame_tick` pulse;
  - pos changes once.
  - Also assert reset release while vertical blank is high: no event occurs.
- Deassert `i_enable` mid-frame at pos 1200:
  - the next cycle shows pos 0, IDLE and `o_bar_active` 0;
  - re-enable, and the first event gives active 1 with pos 0.
- Width 0 sampled at an event: `o_bar_active` = 0 while pos continues sweeping.
